// File: rtl/bf_pred_pkg.sv
// Shared types for the bias-free predictor recency-stack update scheduler:
// FSM state encoding and the in-flight branch entry.
package bf_pred_pkg;

  localparam int BF_PC_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FIXUP   = 2'd1,
    RESTORE = 2'd2
  } bf_sched_state_e;

  typedef struct packed {
    logic [BF_PC_W-1:0] pc;
    logic               dir;
  } bf_spec_entry_t;

endpackage

// File: rtl/bf_rs_update_scheduler_if.sv
// Fetch/execute handshakes plus recency-stack control outputs of the scheduler.
// The slave modport is the scheduler side; master is the front-end/stack side.
interface bf_rs_update_scheduler_if
  import bf_pred_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = BF_PC_W
);

  logic                     pred_valid;
  logic                     pred_ready;
  logic [PC_W-1:0]          pred_pc;
  logic                     pred_dir;

  logic                     res_valid;
  logic                     res_ready;
  logic [PC_W-1:0]          res_pc;
  logic                     res_taken;

  logic                     spec_push;
  logic [PC_W-1:0]          spec_pc;
  logic                     spec_hist;
  logic                     commit_push;
  logic [PC_W-1:0]          commit_pc;
  logic                     commit_hist;
  logic                     restore;
  logic [$clog2(DEPTH):0]   inflight;
  logic                     err_order;

  modport slave (
    input  pred_valid, pred_pc, pred_dir,
    input  res_valid, res_pc, res_taken,
    output pred_ready, res_ready,
    output spec_push, spec_pc, spec_hist,
    output commit_push, commit_pc, commit_hist,
    output restore, inflight, err_order
  );

  modport master (
    output pred_valid, pred_pc, pred_dir,
    output res_valid, res_pc, res_taken,
    input  pred_ready, res_ready,
    input  spec_push, spec_pc, spec_hist,
    input  commit_push, commit_pc, commit_hist,
    input  restore, inflight, err_order
  );

endinterface

// File: rtl/bf_spec_fifo.sv
// Circular queue of in-flight speculative branches, oldest entry exposed at head.
// Flush wins over push/pop in the same cycle.
module bf_spec_fifo
  import bf_pred_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  bf_spec_entry_t         push_data,
  input  logic                   pop,
  input  logic                   flush,
  output bf_spec_entry_t         head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  bf_spec_entry_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Payload storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/bf_rs_update_scheduler.sv
// Sequences speculative/committed recency-stack pushes and the restore after a
// mispredict: RUN -> FIXUP (commit lands) -> RESTORE (copy committed to spec).
module bf_rs_update_scheduler
  import bf_pred_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = BF_PC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  bf_rs_update_scheduler_if.slave   bus
);

  bf_sched_state_e        state_reg;
  bf_spec_entry_t         head;
  bf_spec_entry_t         push_entry;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  logic                   run;
  logic                   pred_fire;
  logic                   res_fire;
  logic                   pc_mismatch;
  logic                   mispredict;

  logic                   spec_push_reg;
  logic [PC_W-1:0]        spec_pc_reg;
  logic                   spec_hist_reg;
  logic                   commit_push_reg;
  logic [PC_W-1:0]        commit_pc_reg;
  logic                   commit_hist_reg;
  logic                   restore_reg;
  logic                   err_order_reg;

  assign run         = (state_reg == RUN);
  assign res_fire    = bus.res_valid && bus.res_ready;
  assign pc_mismatch = (bus.res_pc != head.pc);
  assign mispredict  = res_fire && (pc_mismatch || (bus.res_taken != head.dir));
  assign pred_fire   = bus.pred_valid && bus.pred_ready;

  assign bus.res_ready = run && !empty;
  // A prediction offered alongside a mispredict belongs to the wrong path; refuse it.
  assign bus.pred_ready = run && !full && !mispredict;

  always_comb begin
    push_entry     = '0;
    push_entry.pc  = bus.pred_pc;
    push_entry.dir = bus.pred_dir;
  end

  bf_spec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pred_fire),
    .push_data (push_entry),
    .pop       (res_fire),
    .flush     (mispredict),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= RUN;
      spec_push_reg   <= 1'b0;
      spec_pc_reg     <= '0;
      spec_hist_reg   <= 1'b0;
      commit_push_reg <= 1'b0;
      commit_pc_reg   <= '0;
      commit_hist_reg <= 1'b0;
      restore_reg     <= 1'b0;
      err_order_reg   <= 1'b0;
    end else begin
      spec_push_reg   <= 1'b0;
      commit_push_reg <= 1'b0;
      restore_reg     <= 1'b0;
      case (state_reg)
        RUN: begin
          if (pred_fire) begin
            spec_push_reg <= 1'b1;
            spec_pc_reg   <= bus.pred_pc;
            spec_hist_reg <= bus.pred_dir;
          end
          if (res_fire) begin
            // Commit always records the queued address, even when execute disagrees.
            commit_push_reg <= 1'b1;
            commit_pc_reg   <= head.pc;
            commit_hist_reg <= bus.res_taken;
            if (mispredict) begin
              state_reg <= FIXUP;
            end
            if (pc_mismatch) begin
              err_order_reg <= 1'b1;
            end
          end
        end
        FIXUP: begin
          restore_reg <= 1'b1;
          state_reg   <= RESTORE;
        end
        RESTORE: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign bus.spec_push   = spec_push_reg;
  assign bus.spec_pc     = spec_pc_reg;
  assign bus.spec_hist   = spec_hist_reg;
  assign bus.commit_push = commit_push_reg;
  assign bus.commit_pc   = commit_pc_reg;
  assign bus.commit_hist = commit_hist_reg;
  assign bus.restore     = restore_reg;
  assign bus.inflight    = count;
  assign bus.err_order   = err_order_reg;

endmodule

// File: tb/tb_bf_rs_update_scheduler.sv
// Directed, table-driven bench for the recency-stack update scheduler (DEPTH=8).
module tb_bf_rs_update_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bf_rs_update_scheduler_if bus ();

  bf_rs_update_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [15:0] ppc;
    logic        pd;
    logic        rv;
    logic [15:0] rpc;
    logic        rt;
    logic        e_spush;
    logic [15:0] e_spc;
    logic        e_cpush;
    logic [15:0] e_cpc;
    logic        e_chist;
    logic        e_restore;
    int          e_infl;
    logic        e_pready;
    logic        e_rready;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic [15:0] ppc, input logic pd,
                     input logic rv, input logic [15:0] rpc, input logic rt,
                     input logic es, input logic [15:0] espc,
                     input logic ec, input logic [15:0] ecpc, input logic ech,
                     input logic erst, input int einf,
                     input logic epr, input logic err_r, input logic eerr);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pd = pd;
    v.rv = rv; v.rpc = rpc; v.rt = rt;
    v.e_spush = es; v.e_spc = espc;
    v.e_cpush = ec; v.e_cpc = ecpc; v.e_chist = ech;
    v.e_restore = erst; v.e_infl = einf;
    v.e_pready = epr; v.e_rready = err_r; v.e_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.pred_valid = 1'b0;
    bus.pred_pc    = '0;
    bus.pred_dir   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_pc     = '0;
    bus.res_taken  = 1'b0;
  endtask

  // One clock: drive, take the edge, drop valids, then sample the registered results.
  task automatic step(input logic pv, input logic [15:0] ppc, input logic pd,
                      input logic rv, input logic [15:0] rpc, input logic rt);
    bus.pred_valid = pv;
    bus.pred_pc    = ppc;
    bus.pred_dir   = pd;
    bus.res_valid  = rv;
    bus.res_pc     = rpc;
    bus.res_taken  = rt;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  initial begin
    logic [15:0] drain_pcs [7];
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();

    // Fill to DEPTH, hold a 9th, resolve while full, then paired push/commit.
    for (int i = 0; i < 8; i++) begin
      add(1, 16'h0010 + 16'(i), 1, 0, 0, 0, 1, 16'h0010 + 16'(i), 0, 0, 0, 0, i + 1, (i < 7), 1, 0);
    end
    add(1, 16'h0018, 1, 0, 0,       0, 0, 0,       0, 0,       0, 0, 8, 0, 1, 0);
    add(1, 16'h0018, 1, 1, 16'h0010, 1, 0, 0,       1, 16'h0010, 1, 0, 7, 1, 1, 0);
    add(1, 16'h0018, 1, 1, 16'h0011, 1, 1, 16'h0018, 1, 16'h0011, 1, 0, 7, 1, 1, 0);
    add(1, 16'h0020, 1, 1, 16'h0012, 1, 1, 16'h0020, 1, 16'h0012, 1, 0, 7, 1, 1, 0);
    drain_pcs = '{16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0018, 16'h0020};
    for (int k = 0; k < 7; k++) begin
      add(0, 0, 0, 1, drain_pcs[k], 1, 0, 0, 1, drain_pcs[k], 1, 0, 6 - k, 1, (k < 6), 0);
    end
    // Direction mispredict with a wrong-path prediction offered in the same cycle.
    add(1, 16'h0040, 1, 0, 0,       0, 1, 16'h0040, 0, 0,       0, 0, 1, 1, 1, 0);
    add(1, 16'h0041, 0, 0, 0,       0, 1, 16'h0041, 0, 0,       0, 0, 2, 1, 1, 0);
    add(1, 16'h0042, 1, 0, 0,       0, 1, 16'h0042, 0, 0,       0, 0, 3, 1, 1, 0);
    add(1, 16'h0043, 1, 1, 16'h0040, 0, 0, 0,       1, 16'h0040, 0, 0, 0, 0, 0, 0);
    add(0, 0,        0, 0, 0,       0, 0, 0,       0, 0,       0, 1, 0, 0, 0, 0);
    add(0, 0,        0, 0, 0,       0, 0, 0,       0, 0,       0, 0, 0, 1, 0, 0);
    // PC mismatch with correct direction: same recovery plus sticky err_order.
    add(1, 16'h0050, 1, 0, 0,       0, 1, 16'h0050, 0, 0,       0, 0, 1, 1, 1, 0);
    add(0, 0,        0, 1, 16'h0051, 1, 0, 0,       1, 16'h0050, 1, 0, 0, 0, 0, 1);
    add(0, 0,        0, 0, 0,       0, 0, 0,       0, 0,       0, 1, 0, 0, 0, 1);
    add(0, 0,        0, 0, 0,       0, 0, 0,       0, 0,       0, 0, 0, 1, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_pred_ready", bus.pred_ready, 1);
    chk("reset_res_ready", bus.res_ready, 0);
    chk("reset_inflight", bus.inflight, 0);
    chk("reset_pulses", {bus.spec_push, bus.commit_push, bus.restore}, 0);
    chk("reset_payloads", {bus.spec_pc, bus.spec_hist, bus.commit_pc, bus.commit_hist}, 0);
    chk("reset_err_order", bus.err_order, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].pv, vecs[i].ppc, vecs[i].pd, vecs[i].rv, vecs[i].rpc, vecs[i].rt);
      $display("vec %0d: pred=%0b/%h res=%0b/%h/%0b -> spush=%0b cpush=%0b/%h restore=%0b inflight=%0d",
               i, vecs[i].pv, vecs[i].ppc, vecs[i].rv, vecs[i].rpc, vecs[i].rt,
               bus.spec_push, bus.commit_push, bus.commit_pc, bus.restore, bus.inflight);
      chk($sformatf("v%0d_spec_push", i), bus.spec_push, vecs[i].e_spush);
      if (vecs[i].e_spush) chk($sformatf("v%0d_spec_pc", i), {bus.spec_pc, bus.spec_hist}, {vecs[i].e_spc, vecs[i].pd});
      chk($sformatf("v%0d_commit_push", i), bus.commit_push, vecs[i].e_cpush);
      if (vecs[i].e_cpush) chk($sformatf("v%0d_commit_pc", i), {bus.commit_pc, bus.commit_hist}, {vecs[i].e_cpc, vecs[i].e_chist});
      chk($sformatf("v%0d_restore", i), bus.restore, vecs[i].e_restore);
      chk($sformatf("v%0d_inflight", i), bus.inflight, vecs[i].e_infl);
      chk($sformatf("v%0d_pred_ready", i), bus.pred_ready, vecs[i].e_pready);
      chk($sformatf("v%0d_res_ready", i), bus.res_ready, vecs[i].e_rready);
      chk($sformatf("v%0d_err_order", i), bus.err_order, vecs[i].e_err);
    end

    // Pointer wrap: alternating predict/resolve, order and no spurious restore.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] pc;
      logic        d;
      pc = 16'h0100 + 16'(i);
      d  = i[0];
      step(1, pc, d, 0, 0, 0);
      $display("wrap %0d pred: spush=%0b pc=%h inflight=%0d", i, bus.spec_push, bus.spec_pc, bus.inflight);
      chk($sformatf("wrap%0d_spec", i), {bus.spec_push, bus.spec_pc, bus.spec_hist}, {1'b1, pc, d});
      chk($sformatf("wrap%0d_infl1", i), bus.inflight, 1);
      step(0, 0, 0, 1, pc, d);
      $display("wrap %0d res: cpush=%0b pc=%h inflight=%0d", i, bus.commit_push, bus.commit_pc, bus.inflight);
      chk($sformatf("wrap%0d_commit", i), {bus.commit_push, bus.commit_pc, bus.commit_hist}, {1'b1, pc, d});
      chk($sformatf("wrap%0d_restore", i), bus.restore, 0);
      chk($sformatf("wrap%0d_infl0", i), bus.inflight, 0);
    end

    // Reset asserted mid-FIXUP abandons the pending restore.
    step(1, 16'h0060, 1, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0060, 0);
    chk("fixup_commit_push", bus.commit_push, 1);
    chk("fixup_pred_ready", bus.pred_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    $display("midfixup reset: cpush=%0b restore=%0b inflight=%0d pred_ready=%0b",
             bus.commit_push, bus.restore, bus.inflight, bus.pred_ready);
    chk("midrst_pulses", {bus.spec_push, bus.commit_push, bus.restore}, 0);
    chk("midrst_payloads", {bus.spec_pc, bus.spec_hist, bus.commit_pc, bus.commit_hist}, 0);
    chk("midrst_inflight", bus.inflight, 0);
    chk("midrst_pred_ready", bus.pred_ready, 1);
    chk("midrst_res_ready", bus.res_ready, 0);
    chk("midrst_err_order", bus.err_order, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_restore", c), bus.restore, 0);
      chk($sformatf("post_rst%0d_pred_ready", c), bus.pred_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
